// File: rtl/serial_twos_complementer_param.sv
// Word-framed, bit-serial two's-complement unit: pass, negate or absolute
// value per word, LSB first, fixed latency of WORD_W cycles.
module serial_twos_complementer_param #(
    parameter int unsigned WORD_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_In,
    input  logic       sync,
    input  logic [1:0] mode,
    output logic       data_Out,
    output logic       out_sync,
    output logic       out_valid,
    output logic       ovf,
    output logic [1:0] State_out
);

    localparam int unsigned CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORD_W - 1);
    localparam logic [WORD_W-1:0] MIN_NEG = {1'b1, {(WORD_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        COPY   = 2'b01,
        INVERT = 2'b10,
        PASS   = 2'b11
    } state_t;

    // input framing
    logic              r_armed;
    logic [CW-1:0]     r_cnt;
    logic [WORD_W-2:0] r_shift;
    logic [1:0]        r_mode;

    // output stage
    logic              r_emit;
    logic [CW-1:0]     r_ocnt;
    logic [WORD_W-1:0] r_obuf;
    logic              r_ovf_pend;
    state_t            r_state;
    state_t            w_next_state;
    logic              r_data;
    logic              r_osync;
    logic              r_ovalid;
    logic              r_ovf;

    logic              w_inword;
    logic [CW-1:0]     w_idx;
    logic              w_done;
    logic [WORD_W-1:0] w_word;
    logic              w_active;
    logic              w_last;
    logic              w_bit_out;

    // Word-position decode; a sync always restarts at bit 0.
    always_comb begin
        w_inword = sync | r_armed;
        w_idx    = sync ? '0 : r_cnt;
        w_done   = w_inword && (w_idx == LAST);
        // Bits 0..WORD_W-2 sit in the shift register; the MSB is on the wire now.
        w_word   = {data_In, r_shift};
        w_active = (r_mode == 2'b01) || ((r_mode == 2'b10) && data_In);
        w_last   = r_emit && (r_ocnt == LAST);
    end

    // Output Moore state: next state and emitted bit.
    always_comb begin
        w_next_state = r_state;
        w_bit_out    = 1'b0;
        if (r_emit) begin
            unique case (r_state)
                COPY: begin
                    w_bit_out = r_obuf[0];
                    if (r_obuf[0]) w_next_state = INVERT;
                end
                INVERT:  w_bit_out = ~r_obuf[0];
                default: w_bit_out = r_obuf[0];
            endcase
        end
        if (w_last) w_next_state = IDLE;
        // A word completing on the last-bit edge takes priority over IDLE.
        if (w_done) w_next_state = w_active ? COPY : PASS;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // Input framing: bit counter, word shift register, per-word mode capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_mode  <= '0;
        end else if (w_inword) begin
            r_armed <= 1'b1;
            r_cnt   <= (w_idx == LAST) ? '0 : w_idx + CW'(1);
            r_shift <= (r_shift >> 1) | ((WORD_W-1)'(data_In) << (WORD_W - 2));
            if (w_idx == '0) r_mode <= mode;
        end
    end

    // Emission bookkeeping: load a completed word, then shift it out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_emit     <= 1'b0;
            r_ocnt     <= '0;
            r_obuf     <= '0;
            r_ovf_pend <= 1'b0;
        end else if (w_done) begin
            r_emit     <= 1'b1;
            r_ocnt     <= '0;
            r_obuf     <= w_word;
            r_ovf_pend <= w_active && (w_word == MIN_NEG);
        end else if (r_emit) begin
            r_obuf <= r_obuf >> 1;
            r_ocnt <= r_ocnt + CW'(1);
            if (w_last) r_emit <= 1'b0;
        end
    end

    // Registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data   <= 1'b0;
            r_osync  <= 1'b0;
            r_ovalid <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_data   <= w_bit_out;
            r_osync  <= r_emit && (r_ocnt == '0);
            r_ovalid <= r_emit;
            r_ovf    <= w_last && r_ovf_pend;
        end
    end

    assign data_Out  = r_data;
    assign out_sync  = r_osync;
    assign out_valid = r_ovalid;
    assign ovf       = r_ovf;
    assign State_out = r_state;

endmodule
